idx2d_scan_gen: RTL and testbench



---
 rtl/idx2d_pkg.sv | 13 +
 rtl/idx2d_scan_gen_axis_cnt.sv | 48 ++++
 rtl/idx2d_scan_gen.sv | 141 ++++++++++++++
 tb/tb_idx2d_scan_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idx2d_pkg.sv
// Shared types and default widths for the 2-D raster index generator.
package idx2d_pkg;

    localparam int unsigned X_W_DEF = 6;
    localparam int unsigned Y_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/idx2d_scan_gen_axis_cnt.sv
// Single-axis index counter: latches its extent, clears, increments and
// wraps to zero when the index reaches extent-1.
module idx_axis_cnt #(
    parameter int unsigned W = 6
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         inc_i,
    input  logic [W:0]   size_i,
    output logic [W-1:0] ind_o,
    output logic         at_lim_c
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   size_q, size_d;
    logic [W:0]   lim_c;

    // Limit compare runs one bit wider so an extent of 2^W wraps cleanly.
    always_comb begin
        size_d   = size_q;
        cnt_d    = cnt_q;
        lim_c    = size_q - (W+1)'(1);
        at_lim_c = ({1'b0, cnt_q} == lim_c);
        if (ld_i) begin
            size_d = size_i;
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = at_lim_c ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            size_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            size_q <= size_d;
        end
    end

    assign ind_o = cnt_q;

endmodule

// File: rtl/idx2d_scan_gen.sv
// Raster-order (x fastest) 2-D index generator with valid/ready handshake.
// Optional linear address output enabled by IDX2D_LIN_ADDR_EN.
module idx2d_scan_gen
    import idx2d_pkg::*;
#(
    parameter int unsigned X_W = X_W_DEF,
    parameter int unsigned Y_W = Y_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [X_W:0]   x_size_i,
    input  logic [Y_W:0]   y_size_i,
    input  logic           ready_i,
    output logic           valid_o,
    output logic [X_W-1:0] x_ind_o,
    output logic [Y_W-1:0] y_ind_o,
    output logic           last_o,
    output logic           busy_o,
    output logic           done_o
`ifdef IDX2D_LIN_ADDR_EN
    ,
    output logic [X_W+Y_W-1:0] lin_addr_o
`endif
);

    localparam int unsigned L_W = X_W + Y_W;

    state_e state_q, state_d;
    logic   valid_q, valid_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   start_acc_c;
    logic   acc_c;
    logic   clr_c;
    logic   x_at_lim_c;
    logic   y_at_lim_c;

    // Next state and registered status; abort overrides every state.
    always_comb begin
        state_d     = state_q;
        start_acc_c = 1'b0;
        acc_c       = valid_q && ready_i;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        start_acc_c = 1'b1;
                        if ((x_size_i == '0) || (y_size_i == '0)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (acc_c && x_at_lim_c && y_at_lim_c) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clr_c = start_acc_c || abort_i;

    idx_axis_cnt #(.W(X_W)) u_x_cnt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (clr_c),
        .ld_i     (start_acc_c),
        .inc_i    (acc_c),
        .size_i   (x_size_i),
        .ind_o    (x_ind_o),
        .at_lim_c (x_at_lim_c)
    );

    // y advances only when x wraps on an accepted beat.
    idx_axis_cnt #(.W(Y_W)) u_y_cnt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (clr_c),
        .ld_i     (start_acc_c),
        .inc_i    (acc_c && x_at_lim_c),
        .size_i   (y_size_i),
        .ind_o    (y_ind_o),
        .at_lim_c (y_at_lim_c)
    );

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign last_o  = valid_q && x_at_lim_c && y_at_lim_c;

`ifdef IDX2D_LIN_ADDR_EN
    logic [L_W-1:0] lin_q, lin_d;

    // Raster order makes y*xs+x a plain beat counter.
    always_comb begin
        lin_d = lin_q;
        if (clr_c) begin
            lin_d = '0;
        end else if (acc_c) begin
            lin_d = lin_q + L_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lin_q <= '0;
        end else begin
            lin_q <= lin_d;
        end
    end

    assign lin_addr_o = lin_q;
`endif

endmodule

// File: tb/tb_idx2d_scan_gen.sv
// Scoreboard bench for idx2d_scan_gen; expected beats queued at start,
// popped on each accepted handshake.
module tb_idx2d_scan_gen;

    localparam int X_W = 6;
    localparam int Y_W = 6;

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic           start_i;
    logic           abort_i;
    logic [X_W:0]   x_size_i;
    logic [Y_W:0]   y_size_i;
    logic           ready_i;
    logic           valid_o;
    logic [X_W-1:0] x_ind_o;
    logic [Y_W-1:0] y_ind_o;
    logic           last_o;
    logic           busy_o;
    logic           done_o;
`ifdef IDX2D_LIN_ADDR_EN
    logic [X_W+Y_W-1:0] lin_addr_o;
`endif

    idx2d_scan_gen #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .x_size_i (x_size_i),
        .y_size_i (y_size_i),
        .ready_i  (ready_i),
        .valid_o  (valid_o),
        .x_ind_o  (x_ind_o),
        .y_ind_o  (y_ind_o),
        .last_o   (last_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
`ifdef IDX2D_LIN_ADDR_EN
        ,
        .lin_addr_o (lin_addr_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int x;
        int y;
        bit last;
        int lin;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  hold_pend = 1'b0;
    logic [X_W-1:0] hold_x = '0;
    logic [Y_W-1:0] hold_y = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_scan(input int xs, input int ys);
        for (int y = 0; y < ys; y++) begin
            for (int x = 0; x < xs; x++) begin
                beat_t b;
                b.x    = x;
                b.y    = y;
                b.last = (x == xs - 1) && (y == ys - 1);
                b.lin  = y * xs + x;
                sb.push_back(b);
            end
        end
    endtask

    task automatic launch(input int xs, input int ys);
        start_i  = 1'b1;
        x_size_i = (X_W+1)'(xs);
        y_size_i = (Y_W+1)'(ys);
        push_scan(xs, ys);
        tick();
        start_i = 1'b0;
    endtask

    // Run until done_o (bounded), optionally toggling ready 1,0,0,1.
    task automatic wait_done(input string tag, input int budget, input bit bp);
        int n;
        n = 0;
        while (!done_o && n < budget) begin
            if (bp) ready_i = ((n % 4) == 0) || ((n % 4) == 3);
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(done_o), 32'(1));
        check({tag, "_busy_in_done"}, 32'(busy_o), 32'(1));
        check({tag, "_drain"}, 32'(sb.size()), 32'(0));
        ready_i = 1'b1;
        tick();
        check({tag, "_done_pulse"}, 32'(done_o), 32'(0));
        check({tag, "_busy_low"}, 32'(busy_o), 32'(0));
    endtask

    // Compare each accepted beat and verify stability under backpressure.
    always @(negedge clk_i) begin
        beat_t e;
        if (rst_n_i && valid_o) begin
            if (hold_pend) begin
                check("hold_x", 32'(x_ind_o), 32'(hold_x));
                check("hold_y", 32'(y_ind_o), 32'(hold_y));
            end
            if (ready_i) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("beat_x", 32'(x_ind_o), 32'(e.x));
                    check("beat_y", 32'(y_ind_o), 32'(e.y));
                    check("beat_last", 32'(last_o), 32'(e.last));
`ifdef IDX2D_LIN_ADDR_EN
                    check("beat_lin", 32'(lin_addr_o), 32'(e.lin));
`endif
                end
            end
            hold_pend <= !ready_i;
            hold_x    <= x_ind_o;
            hold_y    <= y_ind_o;
        end else begin
            hold_pend <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n_i  = 1'b0;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        x_size_i = '0;
        y_size_i = '0;
        ready_i  = 1'b1;
        #1;
        check("rst_valid", 32'(valid_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_x", 32'(x_ind_o), 32'(0));
        check("rst_y", 32'(y_ind_o), 32'(0));
        check("rst_last", 32'(last_o), 32'(0));
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();

        // Full-rate 4x3 scan; first valid the cycle after start.
        launch(4, 3);
        check("full_first_valid", 32'(valid_o), 32'(1));
        check("full_busy", 32'(busy_o), 32'(1));
        wait_done("full", 40, 1'b0);

        // Backpressure on 2x2.
        launch(2, 2);
        wait_done("bp", 40, 1'b1);

        // Maximum x extent with a single row.
        launch(64, 1);
        wait_done("xmax", 100, 1'b0);

        // Zero extent: no beats, straight to DONE.
        launch(0, 5);
        check("zero_valid", 32'(valid_o), 32'(0));
        check("zero_done", 32'(done_o), 32'(1));
        tick();
        check("zero_idle_busy", 32'(busy_o), 32'(0));
        check("zero_idle_done", 32'(done_o), 32'(0));

        // 1x1 region: one beat flagged last.
        launch(1, 1);
        check("one_last", 32'(last_o), 32'(1));
        wait_done("one", 10, 1'b0);

        // Start and size changes mid-scan are ignored.
        launch(3, 2);
        tick();
        start_i  = 1'b1;
        x_size_i = 7'd5;
        y_size_i = 7'd5;
        tick();
        start_i = 1'b0;
        wait_done("ign", 40, 1'b0);

        // Abort while the fifth beat of 3x3 is presented.
        launch(3, 3);
        for (int i = 0; i < 4; i++) tick();
        check("abort_pre_x", 32'(x_ind_o), 32'(1));
        check("abort_pre_y", 32'(y_ind_o), 32'(1));
        ready_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        ready_i = 1'b1;
        check("abort_valid", 32'(valid_o), 32'(0));
        check("abort_done", 32'(done_o), 32'(0));
        check("abort_busy", 32'(busy_o), 32'(0));
        sb.delete();
        tick();
        check("abort_no_late_done", 32'(done_o), 32'(0));
        launch(3, 3);
        check("restart_x", 32'(x_ind_o), 32'(0));
        check("restart_y", 32'(y_ind_o), 32'(0));
        wait_done("restart", 40, 1'b0);

        // Abort and start together in IDLE: abort wins.
        start_i  = 1'b1;
        abort_i  = 1'b1;
        x_size_i = 7'd2;
        y_size_i = 7'd2;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check("abort_start_valid", 32'(valid_o), 32'(0));
        check("abort_start_busy", 32'(busy_o), 32'(0));

        // 5x3 exercises the linear address when enabled.
        launch(5, 3);
        wait_done("lin", 40, 1'b0);

        // Asynchronous reset in the middle of a 4x3 scan.
        launch(4, 3);
        for (int i = 0; i < 6; i++) tick();
        check("mid_pre_x", 32'(x_ind_o), 32'(2));
        check("mid_pre_y", 32'(y_ind_o), 32'(1));
        rst_n_i = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 32'(0));
        check("mid_rst_busy", 32'(busy_o), 32'(0));
        check("mid_rst_x", 32'(x_ind_o), 32'(0));
        check("mid_rst_y", 32'(y_ind_o), 32'(0));
        check("mid_rst_last", 32'(last_o), 32'(0));
        sb.delete();
        tick();
        rst_n_i = 1'b1;
        tick();
        check("post_rst_valid", 32'(valid_o), 32'(0));
        check("post_rst_busy", 32'(busy_o), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
